// File: rtl/mem_line_ctrl_if.sv
// Cache-bus request/response bundle between the cache arbiter and mem_line_ctrl.
// Ports: request side (mem_en, mem_rd_wr, mem_burst, mem_addr, mem_wr_data),
//        response side (mem_req_ready, mem_data_valid, mem_rd_data, mem_wr_ack, bus_busy_out).
interface mem_line_ctrl_if;
  logic        mem_en;
  logic        mem_rd_wr;
  logic        mem_burst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_req_ready;
  logic        mem_data_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_ack;
  logic        bus_busy_out;

  // Requester side (arbiter / cache).
  modport master (
    output mem_en, mem_rd_wr, mem_burst, mem_addr, mem_wr_data,
    input  mem_req_ready, mem_data_valid, mem_rd_data, mem_wr_ack, bus_busy_out
  );

  // Memory controller side.
  modport slave (
    input  mem_en, mem_rd_wr, mem_burst, mem_addr, mem_wr_data,
    output mem_req_ready, mem_data_valid, mem_rd_data, mem_wr_ack, bus_busy_out
  );
endinterface

// File: rtl/mem_line_ctrl.sv
// Cycle-accurate memory model on the shared cache bus: word or 4-word line
// reads/writes served from an internal array after LATENCY cycles.
// Ports: clk, reset (sync, active-high), bus (slave side of mem_line_ctrl_if).
module mem_line_ctrl #(
  parameter int LATENCY = 3,   // acceptance edge to first beat, 1..15
  parameter int ADDR_W  = 10   // word-index bits of the array
) (
  input  logic           clk,
  input  logic           reset,
  mem_line_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [1:0]        beat;
  logic [1:0]        last_beat;
  logic              rd_wr_q;
  logic [ADDR_W-3:0] line_q;
  logic [1:0]        word_q;

  logic [31:0] mem [2**ADDR_W];

  // Critical-word-first: word offset wraps inside the 16-byte line.
  logic [1:0]        cur_word;
  logic [1:0]        nxt_word;
  logic [ADDR_W-1:0] first_idx;
  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] nxt_idx;

  always_comb begin
    cur_word  = word_q + beat;
    nxt_word  = word_q + beat + 2'd1;
    first_idx = {line_q, word_q};
    cur_idx   = {line_q, cur_word};
    nxt_idx   = {line_q, nxt_word};
  end

  // Byte-offset bits and bits above the array depth play no role (aliasing).
  wire unused_addr = &{1'b0, bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      lat_cnt            <= '0;
      beat               <= '0;
      last_beat          <= '0;
      rd_wr_q            <= 1'b0;
      line_q             <= '0;
      word_q             <= '0;
      bus.mem_req_ready  <= 1'b1;
      bus.mem_data_valid <= 1'b0;
      bus.mem_rd_data    <= '0;
      bus.mem_wr_ack     <= 1'b0;
      bus.bus_busy_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_en && bus.mem_req_ready) begin
            rd_wr_q           <= bus.mem_rd_wr;
            last_beat         <= bus.mem_burst ? 2'd3 : 2'd0;
            line_q            <= bus.mem_addr[ADDR_W+1:4];
            word_q            <= bus.mem_addr[3:2];
            lat_cnt           <= LAT_INIT;
            state             <= WAIT;
            bus.mem_req_ready <= 1'b0;
            bus.bus_busy_out  <= 1'b1;
          end
        end
        WAIT: begin
          // Count 0 means beat 0 must be on the bus right after this edge.
          if (lat_cnt == 4'd0) begin
            state <= XFER;
            beat  <= 2'd0;
            if (rd_wr_q) begin
              bus.mem_wr_ack <= 1'b1;
            end else begin
              bus.mem_data_valid <= 1'b1;
              bus.mem_rd_data    <= mem[first_idx];
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        XFER: begin
          if (beat == last_beat) begin
            state              <= IDLE;
            beat               <= 2'd0;
            bus.mem_data_valid <= 1'b0;
            bus.mem_wr_ack     <= 1'b0;
            bus.mem_req_ready  <= 1'b1;
            bus.bus_busy_out   <= 1'b0;
          end else begin
            beat <= beat + 2'd1;
            if (!rd_wr_q) begin
              bus.mem_rd_data <= mem[nxt_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write beat lands at the edge that ends its ack cycle; reset aborts further beats
  // but never undoes beats already written.
  always_ff @(posedge clk) begin
    if (!reset && state == XFER && rd_wr_q) begin
      mem[cur_idx] <= bus.mem_wr_data;
    end
  end

endmodule
